// File: rtl/irq_collector_if.sv
// Interrupt collector bus: raw lines and enables in, CPU handshake and
// status out. The collector sits on the slave side; the CPU/stimulus
// side uses the master modport.
interface irq_collector_if #(
  parameter int NUM_CH = 4,
  parameter int ID_W   = 2
);

  logic [NUM_CH-1:0] irq_in;       // raw asynchronous interrupt lines
  logic [NUM_CH-1:0] irq_enable;   // per-channel request enable (0 = masked)
  logic              irq_ack;      // one-cycle acknowledge of presented irq_id
  logic              irq_req;      // at least one enabled pending channel
  logic [ID_W-1:0]   irq_id;       // index of the presented channel
  logic [NUM_CH-1:0] irq_pending;  // raw pending vector, unmasked
  logic [NUM_CH-1:0] irq_overrun;  // sticky: event arrived while already pending

  modport master (
    output irq_in,
    output irq_enable,
    output irq_ack,
    input  irq_req,
    input  irq_id,
    input  irq_pending,
    input  irq_overrun
  );

  modport slave (
    input  irq_in,
    input  irq_enable,
    input  irq_ack,
    output irq_req,
    output irq_id,
    output irq_pending,
    output irq_overrun
  );

endinterface

// File: rtl/irq_collector.sv
// Multi-channel interrupt collector. Each channel synchronises its raw line
// through two flops, debounces it with a FILTER_LEN-cycle agreement filter,
// turns the filtered level into an event (edge or level, per-channel
// polarity) and latches it into a pending bit. The lowest-index enabled
// pending channel is presented to the CPU and retired by a one-cycle ack.
module irq_collector #(
  parameter int               NUM_CH     = 4,
  parameter int               ID_W       = 2,
  parameter int               FILTER_LEN = 4,
  parameter logic [NUM_CH-1:0] ACTIVE_LOW = {NUM_CH{1'b1}},
  parameter logic [NUM_CH-1:0] EDGE_MODE  = {NUM_CH{1'b1}}
) (
  input  logic            clock,
  input  logic            reset,
  irq_collector_if.slave  bus
);

  // Filter counter only needs to count up to FILTER_LEN-1; the step that
  // would reach FILTER_LEN flips the filtered level instead.
  localparam int              CNT_W    = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  // Per-channel state
  logic [NUM_CH-1:0]            sync1_q,     sync1_d;
  logic [NUM_CH-1:0]            sync2_q,     sync2_d;
  logic [NUM_CH-1:0]            filt_q,      filt_d;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q,       cnt_d;
  logic [NUM_CH-1:0]            asrt_prev_q, asrt_prev_d;
  logic [NUM_CH-1:0]            pending_q,   pending_d;
  logic [NUM_CH-1:0]            overrun_q,   overrun_d;

  // Derived per-channel signals
  logic [NUM_CH-1:0] asrt;      // filtered line is at its active level
  logic [NUM_CH-1:0] evt;       // channel raises an interrupt event this cycle
  logic [NUM_CH-1:0] clr;       // accepted ack retires this channel this cycle
  logic [NUM_CH-1:0] masked;    // pending and enabled

  // CPU-facing view
  logic              req;
  logic [ID_W-1:0]   id;
  logic              ack_fire;

  // Request and priority encoder: lowest enabled pending index wins.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment
    // so that no path through the block leaves it unassigned (no latch).
    masked = pending_q & bus.irq_enable;
    req    = |masked;
    id     = '0;
    for (int ch = NUM_CH - 1; ch >= 0; ch--) begin
      if (masked[ch]) begin
        id = ID_W'(ch);
      end
    end
  end

  // Ack acceptance: only a request that is actually being presented is
  // retired, and only the presented channel is cleared.
  always_comb begin
    ack_fire = bus.irq_ack & req;
    clr      = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      clr[ch] = ack_fire && (id == ID_W'(ch));
    end
  end

  // Synchroniser and debounce filter next-state.
  always_comb begin
    sync1_d = bus.irq_in;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    cnt_d   = cnt_q;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (sync2_q[ch] == filt_q[ch]) begin
        cnt_d[ch] = '0;
      end else if (cnt_q[ch] == CNT_LAST) begin
        filt_d[ch] = sync2_q[ch];
        cnt_d[ch]  = '0;
      end else begin
        cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
      end
    end
  end

  // Event generation, pending and overrun next-state. A new event beats a
  // simultaneous ack, so nothing is lost when they coincide.
  always_comb begin
    asrt        = filt_q ^ ACTIVE_LOW;
    asrt_prev_d = asrt;
    evt         = (EDGE_MODE & asrt & ~asrt_prev_q) | (~EDGE_MODE & asrt);
    pending_d   = evt | (pending_q & ~clr);
    overrun_d   = ~clr & (overrun_q | (evt & pending_q));
  end

  // State register with synchronous reset to the inactive line level.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every flop samples the values its
    // neighbours held before this edge, independent of statement order.
    if (reset) begin
      // NOTE: filter and synchroniser state is reset too, not just the
      // pending bits, so a mid-run reset also discards half-filtered pulses.
      sync1_q     <= ACTIVE_LOW;
      sync2_q     <= ACTIVE_LOW;
      filt_q      <= ACTIVE_LOW;
      cnt_q       <= '0;
      asrt_prev_q <= '0;
      pending_q   <= '0;
      overrun_q   <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      filt_q      <= filt_d;
      cnt_q       <= cnt_d;
      asrt_prev_q <= asrt_prev_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
    end
  end

  // Outputs are pure functions of registered state and irq_enable, so an
  // unmask shows up on irq_req in the same cycle.
  assign bus.irq_req     = req;
  assign bus.irq_id      = id;
  assign bus.irq_pending = pending_q;
  assign bus.irq_overrun = overrun_q;

endmodule

// File: tb/tb_irq_collector.sv
// Directed bench for irq_collector: a table of {inputs, cycles, expected
// outputs} records applied in order, plus a hand-written sequence for a
// reset asserted while a level-mode channel is held.
module tb_irq_collector;

  localparam int NUM_CH = 4;
  localparam int ID_W   = 2;

  logic clock;
  logic reset;

  irq_collector_if #(.NUM_CH(NUM_CH), .ID_W(ID_W)) bus_if ();

  irq_collector #(
    .NUM_CH     (NUM_CH),
    .ID_W       (ID_W),
    .FILTER_LEN (4),
    .ACTIVE_LOW (4'b1111),
    .EDGE_MODE  (4'b1011)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    string      name;
    logic [3:0] irq_in;
    logic [3:0] en;
    logic       ack;
    int         n;       // edges to run; 0 = combinational check only
    logic       req;
    logic [1:0] id;
    logic [3:0] pend;
    logic [3:0] ovr;
  } vec_t;

  vec_t vecs[$];
  int   n_total  = 0;
  int   n_passed = 0;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_all(input string name, input logic req, input logic [1:0] id,
                           input logic [3:0] pend, input logic [3:0] ovr);
    check({name, ".req"},  32'(bus_if.irq_req),     32'(req));
    check({name, ".id"},   32'(bus_if.irq_id),      32'(id));
    check({name, ".pend"}, 32'(bus_if.irq_pending), 32'(pend));
    check({name, ".ovr"},  32'(bus_if.irq_overrun), 32'(ovr));
  endtask

  initial begin
    // name, irq_in, en, ack, n, req, id, pend, ovr
    vecs.push_back('{"idle",         4'hF, 4'hF, 1'b0, 3, 1'b0, 2'd0, 4'b0000, 4'b0000});
    // ch1 latency: nothing after 6 edges, request after the 7th
    vecs.push_back('{"ch1_pre",      4'hD, 4'hF, 1'b0, 6, 1'b0, 2'd0, 4'b0000, 4'b0000});
    vecs.push_back('{"ch1_fire",     4'hD, 4'hF, 1'b0, 1, 1'b1, 2'd1, 4'b0010, 4'b0000});
    vecs.push_back('{"ch1_ack",      4'hD, 4'hF, 1'b1, 1, 1'b0, 2'd0, 4'b0000, 4'b0000});
    vecs.push_back('{"ch1_held",     4'hD, 4'hF, 1'b0, 8, 1'b0, 2'd0, 4'b0000, 4'b0000});
    vecs.push_back('{"ch1_release",  4'hF, 4'hF, 1'b0, 8, 1'b0, 2'd0, 4'b0000, 4'b0000});
    // glitch rejection on ch0: 3 low cycles rejected, 4 accepted
    vecs.push_back('{"glitch3_lo",   4'hE, 4'hF, 1'b0, 3, 1'b0, 2'd0, 4'b0000, 4'b0000});
    vecs.push_back('{"glitch3_hi",   4'hF, 4'hF, 1'b0, 8, 1'b0, 2'd0, 4'b0000, 4'b0000});
    vecs.push_back('{"glitch4_lo",   4'hE, 4'hF, 1'b0, 4, 1'b0, 2'd0, 4'b0000, 4'b0000});
    vecs.push_back('{"glitch4_hi",   4'hF, 4'hF, 1'b0, 8, 1'b1, 2'd0, 4'b0001, 4'b0000});
    vecs.push_back('{"glitch4_ack",  4'hF, 4'hF, 1'b1, 1, 1'b0, 2'd0, 4'b0000, 4'b0000});
    // priority: ch3 and ch1 together, held ack retires one per cycle
    vecs.push_back('{"prio_assert",  4'h5, 4'hF, 1'b0, 7, 1'b1, 2'd1, 4'b1010, 4'b0000});
    vecs.push_back('{"prio_ack1",    4'h5, 4'hF, 1'b1, 1, 1'b1, 2'd3, 4'b1000, 4'b0000});
    vecs.push_back('{"prio_ack3",    4'h5, 4'hF, 1'b1, 1, 1'b0, 2'd0, 4'b0000, 4'b0000});
    vecs.push_back('{"prio_release", 4'hF, 4'hF, 1'b0, 8, 1'b0, 2'd0, 4'b0000, 4'b0000});
    // mask on ch2 (level mode), unmask shows in the same cycle
    vecs.push_back('{"mask_pend",    4'hB, 4'hB, 1'b0, 7, 1'b0, 2'd0, 4'b0100, 4'b0000});
    vecs.push_back('{"mask_unmask",  4'hB, 4'hF, 1'b0, 0, 1'b1, 2'd2, 4'b0100, 4'b0000});
    vecs.push_back('{"level_ack",    4'hB, 4'hF, 1'b1, 1, 1'b1, 2'd2, 4'b0100, 4'b0000});
    vecs.push_back('{"level_hold",   4'hB, 4'hF, 1'b0, 1, 1'b1, 2'd2, 4'b0100, 4'b0100});
    vecs.push_back('{"level_rel",    4'hF, 4'hF, 1'b0, 8, 1'b1, 2'd2, 4'b0100, 4'b0100});
    vecs.push_back('{"level_done",   4'hF, 4'hF, 1'b1, 1, 1'b0, 2'd0, 4'b0000, 4'b0000});
    // overrun on ch0, then ack coinciding with a fresh event
    vecs.push_back('{"ovr_first",    4'hE, 4'hF, 1'b0, 7, 1'b1, 2'd0, 4'b0001, 4'b0000});
    vecs.push_back('{"ovr_rel",      4'hF, 4'hF, 1'b0, 8, 1'b1, 2'd0, 4'b0001, 4'b0000});
    vecs.push_back('{"ovr_second",   4'hE, 4'hF, 1'b0, 7, 1'b1, 2'd0, 4'b0001, 4'b0001});
    vecs.push_back('{"ovr_rel2",     4'hF, 4'hF, 1'b0, 8, 1'b1, 2'd0, 4'b0001, 4'b0001});
    vecs.push_back('{"sw_pre",       4'hE, 4'hF, 1'b0, 6, 1'b1, 2'd0, 4'b0001, 4'b0001});
    vecs.push_back('{"sw_ack",       4'hE, 4'hF, 1'b1, 1, 1'b1, 2'd0, 4'b0001, 4'b0000});
    vecs.push_back('{"sw_ack2",      4'hE, 4'hF, 1'b1, 1, 1'b0, 2'd0, 4'b0000, 4'b0000});
    vecs.push_back('{"ack_idle",     4'hE, 4'hF, 1'b1, 2, 1'b0, 2'd0, 4'b0000, 4'b0000});
    vecs.push_back('{"final_rel",    4'hF, 4'hF, 1'b0, 8, 1'b0, 2'd0, 4'b0000, 4'b0000});

    // Reset with all lines idle.
    reset             = 1'b1;
    bus_if.irq_in     = 4'hF;
    bus_if.irq_enable = 4'hF;
    bus_if.irq_ack    = 1'b0;
    tick(2);
    check_all("reset", 1'b0, 2'd0, 4'b0000, 4'b0000);
    reset = 1'b0;

    foreach (vecs[i]) begin
      bus_if.irq_in     = vecs[i].irq_in;
      bus_if.irq_enable = vecs[i].en;
      bus_if.irq_ack    = vecs[i].ack;
      if (vecs[i].n == 0) #1;
      else tick(vecs[i].n);
      check_all(vecs[i].name, vecs[i].req, vecs[i].id, vecs[i].pend, vecs[i].ovr);
    end

    // Level-mode ch2 held asserted, reset mid-hold, then re-qualification.
    bus_if.irq_ack = 1'b0;
    bus_if.irq_in  = 4'hB;
    tick(7);
    check_all("rst_hold_pend", 1'b1, 2'd2, 4'b0100, 4'b0000);
    tick(3);
    reset = 1'b1;
    tick(1);
    check_all("rst_mid", 1'b0, 2'd0, 4'b0000, 4'b0000);
    reset = 1'b0;
    tick(6);
    check_all("rst_requal_pre", 1'b0, 2'd0, 4'b0000, 4'b0000);
    tick(1);
    check_all("rst_requal", 1'b1, 2'd2, 4'b0100, 4'b0000);
    bus_if.irq_in = 4'hF;
    tick(8);
    bus_if.irq_ack = 1'b1;
    tick(1);
    bus_if.irq_ack = 1'b0;
    check_all("rst_cleanup", 1'b0, 2'd0, 4'b0000, 4'b0000);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule

// File: doc/irq_collector.md
Name: irq_collector

Overview:
- Parametrised multi-channel hardware interrupt collector. Successor to the single-button, fixed 4-sample falling-edge detector.
- Per channel:
  - synchronises a raw asynchronous line (button, peripheral);
  - debounces it with a programmable-length filter;
  - detects assertion by edge or by level, with per-channel polarity;
  - latches a pending bit.
- Presents the highest-priority enabled pending channel to the CPU through a request/acknowledge handshake.

Parameters:
- NUM_CH, 4, number of interrupt channels (1..32).
- ID_W, 2, width of irq_id; must satisfy 2**ID_W >= NUM_CH.
- FILTER_LEN, 4, consecutive cycles a synchronised level must differ from the filtered level before the filter flips (>=1).
- ACTIVE_LOW, {NUM_CH{1'b1}}, per-channel polarity. 1 = line asserted when low.
- EDGE_MODE, {NUM_CH{1'b1}}, per-channel mode. 1 = event on filtered assertion edge; 0 = level-sensitive.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- irq_in  in  NUM_CH  raw asynchronous interrupt lines
- irq_enable  in  NUM_CH  per-channel request enable (mask = 0)
- irq_ack  in  1  one-cycle acknowledge of the currently presented irq_id
- irq_req  out  1  at least one enabled pending channel
- irq_id  out  ID_W  index of the presented channel
- irq_pending  out  NUM_CH  raw pending vector, unmasked
- irq_overrun  out  NUM_CH  sticky: event arrived while channel already pending

Behaviour:
- Reset (synchronous, active-high): at the rising edge with reset=1:
  - synchroniser flops and filtered levels load the inactive level (1 where ACTIVE_LOW, else 0);
  - filter counters load 0;
  - pending and overrun load 0;
  - hence irq_req=0, irq_id=0, irq_pending=0, irq_overrun=0.
  - Reset asserted mid-operation discards all pending and in-flight filter state.
- Synchroniser: 2 flops per channel. s2 is the synchronised level.
- Filter (per channel counter, width clog2(FILTER_LEN+1)):
  - if s2 == filt, the counter clears;
  - otherwise it increments;
  - when the increment would reach FILTER_LEN, filt <= s2 and the counter clears in the same edge.
  - Pulses shorter than FILTER_LEN cycles at s2 are rejected.
- Assertion: asrt = filt XOR ACTIVE_LOW[ch].
  - Edge mode: event = asrt rises (registered previous asrt compared).
  - Level mode: event = asrt.
- Pending update per edge:
  - event sets pending;
  - irq_ack && irq_req && irq_id==ch clears pending;
  - when set and clear coincide, set wins and the event is not lost.
  - Level-mode channels therefore stay pending while asserted.
- Overrun: event while pending=1 and not cleared in this edge sets overrun[ch]. Overrun clears only when that channel's ack is accepted, or on reset.
- Output (combinational from registers):
  - irq_req = |(pending & irq_enable);
  - irq_id = lowest index with pending & irq_enable, 0 if none.
  - Lowest index = highest priority.
- Latency: raw line asserted and stable, first sampled high-active at edge 0 → filt flips at edge FILTER_LEN+1, pending set and irq_req=1 at edge FILTER_LEN+2. With defaults, irq_req rises after the 7th edge.
- Ack rules:
  - ack with irq_req=0 is ignored;
  - ack clears only the presented channel;
  - after ack, irq_id moves to the next pending channel in the following cycle, with no dead cycle when others are pending.
- Masked channels still latch pending and overrun but never drive irq_req or irq_id. Unmasking an already-pending channel raises irq_req the same cycle irq_enable changes.
- After reset release, a line already held asserted:
  - produces one event once it passes the filter (edge mode);
  - produces a continuous event (level mode).
- Ack accepted only when irq_ack is high for one cycle. Holding irq_ack high acks successive channels, one per cycle.

Test Plan:
- Defaults, ch1 irq_in driven low and held → irq_req=1 and irq_id=1 exactly after the 7th edge. Pulse irq_ack → irq_pending[1]=0, irq_req=0 next cycle, no re-fire while held low.
- Glitch: ch0 low for 3 cycles then high (FILTER_LEN=4) → irq_pending stays 0. Low for 4 cycles → pending[0] sets.
- Priority: ch3 and ch1 pending, enable=4'b1111 → irq_id=1. Ack → irq_id=3 next cycle. Ack → irq_req=0.
- Mask: ch2 pending with enable=4'b1011 → irq_req=0, irq_pending=4'b0100. Set enable[2]=1 → irq_req=1, irq_id=2 same cycle.
- Overrun and set-wins:
  - second filtered edge on ch0 before ack → irq_overrun[0]=1;
  - ack coinciding with a new ch0 event → pending[0] stays 1, overrun[0] clears.
- Level mode (EDGE_MODE[2]=0): ch2 held asserted, ack → pending[2] remains 1. Assert reset mid-hold → all outputs 0 at next edge, then pending[2] re-sets FILTER_LEN+3 edges after reset release.
